// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the video RAM arbiter: owner encoding, RAM geometry,
// sprite window base and the starvation-limit clamp.
package vram_arbiter_pkg;

  localparam int VRAM_ADDR_W  = 15;
  localparam int VRAM_DATA_W  = 16;
  localparam int STARVE_CTR_W = 7;

  localparam logic [8:0] SPR_BASE_DEF = 9'b111111100;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_TILE = 2'd1,
    OWN_SPR  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_t;

  // Limit 0 would force a CPU slot every cycle; keep it within 1..127.
  function automatic logic [STARVE_CTR_W-1:0] starve_clamp(input int v);
    if (v < 32'sd1) begin
      return 7'd1;
    end else if (v > 32'sd127) begin
      return 7'd127;
    end else begin
      return v[STARVE_CTR_W-1:0];
    end
  endfunction

endpackage

// File: rtl/vram_starve_ctr.sv
// Saturating count of consecutive held CPU cycles and the registered
// forced-CPU-slot flag derived from it.
import vram_arbiter_pkg::*;

module vram_starve_ctr #(
  parameter logic [STARVE_CTR_W-1:0] LIMIT = 7'd64
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic cpu_hold,
  input  logic cpu_gnt,
  output logic force_cpu
);

  logic [STARVE_CTR_W-1:0] cnt_r;
  logic [STARVE_CTR_W-1:0] cnt_nxt_s;
  logic                    force_r;

  // Next count: clear once the CPU is served or idle, saturate at all-ones.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (cpu_gnt || !cpu_req) begin
      cnt_nxt_s = {STARVE_CTR_W{1'b0}};
    end else if (cpu_hold && (cnt_r != {STARVE_CTR_W{1'b1}})) begin
      cnt_nxt_s = cnt_r + 7'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter and force flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r   <= {STARVE_CTR_W{1'b0}};
      force_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      force_r <= (cnt_nxt_s >= LIMIT);
    end
  end

  assign force_cpu = force_r;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: sprite > tile > CPU, read-owner tagging, CPU hold.
// Define VRAM_ARB_STARVE_EN to add the CPU starvation guard (forced CPU slot).
import vram_arbiter_pkg::*;

module vram_arbiter #(
  parameter int         ADDR_W     = VRAM_ADDR_W,
  parameter int         DATA_W     = VRAM_DATA_W,
  parameter int         STARVE_MAX = 64,
  parameter logic [8:0] SPR_BASE   = SPR_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tile_req,
  input  logic [15:0]       tile_addr,
  output logic              tile_gnt,
  output logic              tile_rvalid,
  input  logic              spr_req,
  input  logic [5:0]        spr_addr,
  output logic              spr_gnt,
  output logic              spr_rvalid,
  input  logic              cpu_req,
  input  logic [15:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic              cpu_hold,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [STARVE_CTR_W-1:0] STARVE_LIM = starve_clamp(STARVE_MAX);

  owner_t gnt_s;
  owner_t owner_r;
  logic   cpu_ram_req_s;
  logic   cpu_gnt_s;
  logic   force_s;
  logic   unused_s;

  // ROM-space CPU cycles (bit 15) are invisible to the RAM side.
  assign cpu_ram_req_s = cpu_req & ~cpu_addr[15];

`ifdef VRAM_ARB_STARVE_EN
  logic force_flag_s;

  vram_starve_ctr #(
    .LIMIT(STARVE_LIM)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_hold (cpu_hold),
    .cpu_gnt  (cpu_gnt_s),
    .force_cpu(force_flag_s)
  );

  assign force_s = force_flag_s & cpu_ram_req_s;
`else
  assign force_s = 1'b0;
`endif

  assign unused_s = ^{tile_addr[15], STARVE_LIM};

  // Grant selection; everything is quiet while reset is asserted.
  always_comb begin
    gnt_s = OWN_IDLE;
    if (!reset) begin
      gnt_s = OWN_IDLE;
    end else if (force_s) begin
      gnt_s = OWN_CPU;
    end else if (spr_req) begin
      gnt_s = OWN_SPR;
    end else if (tile_req) begin
      gnt_s = OWN_TILE;
    end else if (cpu_ram_req_s) begin
      gnt_s = OWN_CPU;
    end else begin
      gnt_s = OWN_IDLE;
    end
  end

  assign spr_gnt   = (gnt_s == OWN_SPR);
  assign tile_gnt  = (gnt_s == OWN_TILE);
  assign cpu_gnt_s = (gnt_s == OWN_CPU);
  assign cpu_hold  = cpu_ram_req_s & ~cpu_gnt_s;
  assign ram_we    = cpu_gnt_s & cpu_we & ~cpu_addr[15];
  assign ram_din   = cpu_wdata;
  assign rd_data   = ram_dout;

  // RAM address mux driven by the granted master.
  always_comb begin
    ram_addr = {ADDR_W{1'b0}};
    case (gnt_s)
      OWN_SPR:  ram_addr = ADDR_W'({SPR_BASE, spr_addr});
      OWN_TILE: ram_addr = tile_addr[ADDR_W-1:0];
      OWN_CPU:  ram_addr = cpu_addr[ADDR_W-1:0];
      default:  ram_addr = {ADDR_W{1'b0}};
    endcase
  end

  // Owner of the RAM data arriving next cycle; writes return nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r <= OWN_IDLE;
    end else begin
      case (gnt_s)
        OWN_CPU: owner_r <= cpu_we ? OWN_IDLE : OWN_CPU;
        default: owner_r <= gnt_s;
      endcase
    end
  end

  assign tile_rvalid = (owner_r == OWN_TILE);
  assign spr_rvalid  = (owner_r == OWN_SPR);
  assign cpu_rvalid  = (owner_r == OWN_CPU);

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic against a
// rule-level model with its own RAM shadow; works with or without VRAM_ARB_STARVE_EN.
module tb_vram_arbiter;

  localparam int LIM = 4;
`ifdef VRAM_ARB_STARVE_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        tile_req, spr_req, cpu_req, cpu_we;
  logic [15:0] tile_addr, cpu_addr, cpu_wdata;
  logic [5:0]  spr_addr;
  logic        tile_gnt, tile_rvalid, spr_gnt, spr_rvalid, cpu_hold, cpu_rvalid;
  logic [14:0] ram_addr;
  logic [15:0] ram_din, ram_dout, rd_data;
  logic        ram_we;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.STARVE_MAX(LIM)) dut (
    .clk(clk), .reset(reset),
    .tile_req(tile_req), .tile_addr(tile_addr), .tile_gnt(tile_gnt), .tile_rvalid(tile_rvalid),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_gnt(spr_gnt), .spr_rvalid(spr_rvalid),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_hold(cpu_hold), .cpu_rvalid(cpu_rvalid),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .rd_data(rd_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pattern(input int a);
    return 16'((a * 7) ^ 32'h5A5A);
  endfunction

  // Synchronous RAM the arbiter drives.
  logic [15:0] env_mem [0:32767];
  initial begin
    ram_dout = 16'h0000;
    for (int i = 0; i < 32768; i++) env_mem[i] = pattern(i);
    env_mem[32'h6020] = 16'h1234;
    forever begin
      @(posedge clk);
      if (ram_we) env_mem[ram_addr] <= ram_din;
      ram_dout <= env_mem[ram_addr];
    end
  end

  // Reference model: 0 none, 1 tile, 2 sprite, 3 cpu.
  logic [15:0] shadow [0:32767];
  int          m_cnt;
  int          m_pend;
  logic [15:0] m_pend_data;

  function automatic int exp_who();
    bit cpu_ok;
    cpu_ok = cpu_req && !cpu_addr[15];
    if (!reset) return 0;
    if (GUARD && cpu_ok && m_cnt >= LIM) return 3;
    if (spr_req) return 2;
    if (tile_req) return 1;
    if (cpu_ok) return 3;
    return 0;
  endfunction

  function automatic logic [14:0] exp_addr(input int who);
    case (who)
      2:       return 15'(32'h7F00 + 32'(spr_addr));
      1:       return tile_addr[14:0];
      3:       return cpu_addr[14:0];
      default: return 15'd0;
    endcase
  endfunction

  initial begin
    int who;
    m_cnt = 0;
    m_pend = 0;
    m_pend_data = 16'h0000;
    for (int i = 0; i < 32768; i++) shadow[i] = pattern(i);
    shadow[32'h6020] = 16'h1234;
    forever begin
      @(posedge clk);
      who = exp_who();
      if (!reset) begin
        m_pend <= 0;
        m_cnt  <= 0;
      end else begin
        if (who == 3 && cpu_we) begin
          shadow[cpu_addr[14:0]] <= cpu_wdata;
          m_pend <= 0;
        end else begin
          m_pend      <= who;
          m_pend_data <= shadow[exp_addr(who)];
        end
        if (who == 3 || !cpu_req) m_cnt <= 0;
        else if (!cpu_addr[15]) m_cnt <= (m_cnt < 127) ? m_cnt + 1 : 127;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : cmp
    int cw;
    cw = exp_who();
    chk("spr_gnt",  32'(spr_gnt),  32'(cw == 2));
    chk("tile_gnt", 32'(tile_gnt), 32'(cw == 1));
    chk("ram_addr", 32'(ram_addr), 32'(exp_addr(cw)));
    chk("ram_we",   32'(ram_we),   32'(cw == 3 && cpu_we));
    chk("ram_din",  32'(ram_din),  32'(cpu_wdata));
    chk("cpu_hold", 32'(cpu_hold), 32'(cpu_req && !cpu_addr[15] && cw != 3));
    chk("tile_rvalid", 32'(tile_rvalid), 32'(reset && m_pend == 1));
    chk("spr_rvalid",  32'(spr_rvalid),  32'(reset && m_pend == 2));
    chk("cpu_rvalid",  32'(cpu_rvalid),  32'(reset && m_pend == 3));
    if (reset && m_pend != 0) chk("rd_data", 32'(rd_data), 32'(m_pend_data));
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int holds;
    bit got;
    int g;
    reset = 1'b0;
    tile_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    tile_addr = 16'h0; cpu_addr = 16'h0; cpu_wdata = 16'h0; spr_addr = 6'd0;

    // All requests up while in reset.
    next();
    spr_req = 1'b1; spr_addr = 6'd5; tile_req = 1'b1; tile_addr = 16'h6020;
    cpu_req = 1'b1; cpu_addr = 16'h0100;
    @(negedge clk);
    chk("rst_gnts", 32'({spr_gnt, tile_gnt, ram_we}), 32'h0);
    chk("rst_addr", 32'(ram_addr), 32'h0);
    chk("rst_hold", 32'(cpu_hold), 32'h1);

    next(); reset = 1'b1;
    @(negedge clk);
    chk("first_spr_gnt", 32'(spr_gnt), 32'h1);
    chk("spr_addr_7f05", 32'(ram_addr), 32'h7F05);
    chk("spr_over_tile", 32'(tile_gnt), 32'h0);

    next(); spr_req = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    chk("tile_after_spr", 32'(tile_gnt), 32'h1);
    chk("tile_addr_6020", 32'(ram_addr), 32'h6020);
    chk("spr_rvalid_lit", 32'(spr_rvalid), 32'h1);

    next(); tile_req = 1'b0;
    @(negedge clk);
    chk("tile_rvalid_lit", 32'(tile_rvalid), 32'h1);
    chk("tile_data_1234", 32'(rd_data), 32'h1234);

    // CPU write then readback.
    next(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4FFE; cpu_wdata = 16'hBEEF;
    @(negedge clk);
    chk("cpu_wr_we", 32'(ram_we), 32'h1);
    chk("cpu_wr_addr", 32'(ram_addr), 32'h4FFE);
    next(); cpu_we = 1'b0;
    @(negedge clk);
    chk("wr_no_rvalid", 32'(cpu_rvalid), 32'h0);
    next(); cpu_req = 1'b0;
    @(negedge clk);
    chk("cpu_rvalid_lit", 32'(cpu_rvalid), 32'h1);
    chk("readback_beef", 32'(rd_data), 32'hBEEF);

    // ROM-space CPU cycle alongside a tile read.
    next(); tile_req = 1'b1; tile_addr = 16'h0042; cpu_req = 1'b1; cpu_addr = 16'h8010; cpu_we = 1'b1;
    @(negedge clk);
    chk("rom_no_hold", 32'(cpu_hold), 32'h0);
    chk("rom_no_we", 32'(ram_we), 32'h0);
    chk("rom_tile_gnt", 32'(tile_gnt), 32'h1);
    next(); tile_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    next();

    // Continuous tile traffic against a CPU read.
    tile_req = 1'b1; tile_addr = 16'h0300; cpu_req = 1'b1; cpu_addr = 16'h1234;
    holds = 0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (cpu_hold) holds++;
      else begin
        got = 1'b1;
        chk("forced_tile_off", 32'(tile_gnt), 32'h0);
        chk("forced_addr", 32'(ram_addr), 32'h1234);
      end
      next();
    end
`ifdef VRAM_ARB_STARVE_EN
    chk("starve_holds", 32'(holds), 32'd4);
    chk("starve_granted", 32'(got), 32'h1);
`else
    chk("starve_holds", 32'(holds), 32'd100);
    chk("starve_granted", 32'(got), 32'h0);
`endif
    tile_req = 1'b0; cpu_req = 1'b0;

    // Randomized traffic; video masters keep request and address until granted.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      g = exp_who();
      next();
      reset = ($urandom_range(0, 149) != 0);
      if (!(spr_req && g != 2)) begin
        spr_req  = ($urandom_range(0, 3) == 0);
        spr_addr = 6'($urandom_range(0, 63));
      end
      if (!(tile_req && g != 1)) begin
        tile_req = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) tile_addr = 16'h7F00 + 16'($urandom_range(0, 63));
        else tile_addr = 16'h4FF0 + 16'($urandom_range(0, 15));
        tile_addr[15] = 1'($urandom_range(0, 1));
      end
      cpu_req = 1'($urandom_range(0, 1));
      cpu_we  = 1'($urandom_range(0, 1));
      cpu_wdata = 16'($urandom);
      if ($urandom_range(0, 3) == 0) cpu_addr = 16'h7F00 + 16'($urandom_range(0, 63));
      else cpu_addr = 16'h4FF0 + 16'($urandom_range(0, 15));
      cpu_addr[15] = ($urandom_range(0, 7) == 0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
